multicycle_controller: RTL

Multicycle successor to the single-cycle ARM controller. An FSM sequences each instruction over 3–5 cycles (Fetch/Decode/Execute/Memory/Writeback). It owns the ALU-op decode, the architectural NZCV flag register and the condition check. It adds a memory ready handshake so fetch, load and store can stall on slow memory. It sits beside the multicycle datapath and drives all of its mux selects and enables.

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM controller: sequences Fetch/Decode/Execute/Memory/Writeback,
// decodes the ALU operation, holds NZCV and evaluates the condition field.
module multicycle_controller #(
    parameter int          ALUCW         = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter logic [3:0]  RESET_FLAGS   = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [ALUCW-1:0] ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             RegWrite,
    output logic [3:0]       Flags,
    output logic [3:0]       State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_UNDEF  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_flags;

    logic [1:0] w_op;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_sbit;
    logic [3:0] w_rd;
    logic       w_mem_ready;
    logic       w_cond_ex;

    logic [2:0] w_dp_op;
    logic       w_no_write;
    logic       w_s_eff;
    logic       w_arith;
    logic [1:0] w_flag_w;

    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_flag_en;
    logic [2:0] w_alu_op;
    logic       w_wb_en;
    logic       w_unused;

    assign w_op        = Instr[27:26];
    assign w_imm       = Instr[25];
    assign w_cmd       = Instr[24:21];
    assign w_sbit      = Instr[20];
    assign w_rd        = Instr[15:12];
    assign w_mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign w_unused    = &{1'b0, Instr[19:16], Instr[11:0]};

    // Data-processing cmd decode; compare/test always set flags and never write back.
    always_comb begin
        w_dp_op    = ALU_ADD;
        w_no_write = 1'b0;
        w_s_eff    = w_sbit;
        w_arith    = 1'b0;
        case (w_cmd)
            4'b0100: begin w_dp_op = ALU_ADD; w_arith = 1'b1; end
            4'b0010: begin w_dp_op = ALU_SUB; w_arith = 1'b1; end
            4'b0000: w_dp_op = ALU_AND;
            4'b1100: w_dp_op = ALU_ORR;
            4'b0001: w_dp_op = ALU_EOR;
            4'b1010: begin
                w_dp_op    = ALU_SUB;
                w_arith    = 1'b1;
                w_no_write = 1'b1;
                w_s_eff    = 1'b1;
            end
            4'b1000: begin
                w_dp_op    = ALU_AND;
                w_no_write = 1'b1;
                w_s_eff    = 1'b1;
            end
            default: begin
                w_dp_op    = ALU_ADD;
                w_no_write = 1'b1;
            end
        endcase
        w_flag_w = {w_s_eff, w_s_eff & w_arith};
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = r_flags;
        case (Instr[31:28])
            4'b0000: w_cond_ex = z;
            4'b0001: w_cond_ex = ~z;
            4'b0010: w_cond_ex = c;
            4'b0011: w_cond_ex = ~c;
            4'b0100: w_cond_ex = n;
            4'b0101: w_cond_ex = ~n;
            4'b0110: w_cond_ex = v;
            4'b0111: w_cond_ex = ~v;
            4'b1000: w_cond_ex = c & ~z;
            4'b1001: w_cond_ex = ~c | z;
            4'b1010: w_cond_ex = (n == v);
            4'b1011: w_cond_ex = (n != v);
            4'b1100: w_cond_ex = ~z & (n == v);
            4'b1101: w_cond_ex = z | (n != v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_flag_en    = 1'b0;
        w_wb_en      = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        w_alu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = w_mem_ready;
                w_pc_write = w_mem_ready;
                if (w_mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    2'b01:   w_next_state = S_MEMADR;
                    2'b00:   w_next_state = w_imm ? S_EXECI : S_EXECR;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_UNDEF;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB      = 2'b01;
                w_next_state = w_sbit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (w_mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                w_wb_en      = w_cond_ex;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                w_mem_write = w_cond_ex;
                if (w_mem_ready) w_next_state = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB      = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu_op     = w_dp_op;
                w_flag_en    = w_cond_ex;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_wb_en      = w_cond_ex & ~w_no_write;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                w_pc_write   = w_cond_ex;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
        // A writeback to R15 is redirected to the PC enable.
        if (w_wb_en) begin
            if (w_rd == 4'd15) w_pc_write  = 1'b1;
            else               w_reg_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= RESET_FLAGS;
        end else begin
            if (w_flag_en & w_flag_w[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flag_en & w_flag_w[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Enables are gated by the reset pin so nothing commits while it is held.
    assign PCWrite    = w_pc_write  & reset;
    assign IRWrite    = w_ir_write  & reset;
    assign MemWrite   = w_mem_write & reset;
    assign RegWrite   = w_reg_write & reset;
    assign ALUControl = ALUCW'(w_alu_op);
    assign ImmSrc     = w_op;
    assign RegSrc     = {(w_op == 2'b01) & ~w_sbit, (w_op == 2'b10)};
    assign Flags      = r_flags;
    assign State      = r_state;

endmodule
